// File: rtl/program_loader_seq.sv
// Test-harness sequencer: copies per-core data windows from a shared source
// memory into each core's RAM, kicks the cores and collects sticky done flags.
// Parallel mode loads all cores then runs them together; rotate mode loads,
// runs and finishes one core at a time. Includes a run timeout and a
// saturating RUN cycle counter.

// Per-core sticky done flag. A flag only arms once its core has been kicked,
// so a core_done that is high before the kick is ignored until the first RUN
// edge after it.
module program_loader_flag (
  input  logic clk,
  input  logic init,
  input  logic clr,
  input  logic kick,
  input  logic run,
  input  logic core_done,
  output logic flag_nx
);
  logic started_q, started_d;
  logic flag_q, flag_d;

  // next flag/armed state: clear on new sequence, re-arm on kick, set in RUN
  always_comb begin
    started_d = started_q;
    flag_d    = flag_q;
    if (clr) begin
      started_d = 1'b0;
      flag_d    = 1'b0;
    end else if (kick) begin
      started_d = 1'b1;
      flag_d    = 1'b0;
    end else if (run && started_q && core_done) begin
      flag_d = 1'b1;
    end
  end

  // flag registers
  always_ff @(posedge clk) begin
    if (init) begin
      started_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      started_q <= started_d;
      flag_q    <= flag_d;
    end
  end

  // the value the flag takes at this edge, so RUN can end on the same edge
  assign flag_nx = flag_d;
endmodule

module program_loader_seq #(
  parameter int N_CORES = 3,
  parameter int AW = 8,
  parameter int DW = 8,
  parameter logic [N_CORES*AW-1:0] WIN_BASE = {8'd128, 8'd32, 8'd1},
  parameter logic [N_CORES*(AW+1)-1:0] WIN_LEN = {9'd20, 9'd64, 9'd3},
  parameter int TIMEOUT = 65535,
  parameter int CW = 16,
  localparam int CCW = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic               clk,
  input  logic               init,
  input  logic               start,
  input  logic               mode,
  output logic [AW-1:0]      src_addr,
  input  logic [DW-1:0]      src_data,
  output logic [N_CORES-1:0] wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [N_CORES-1:0] core_start,
  input  logic [N_CORES-1:0] core_done,
  output logic [CCW-1:0]     cur_core,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CW-1:0]      run_cycles
);
  // KICK is the single core_start cycle between LOAD and RUN; it is not a
  // RUN cycle, so it is neither counted nor used to sample core_done.
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_KICK, ST_RUN, ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [CCW-1:0]       cur_q, cur_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [N_CORES-1:0]   wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [31:0]          tmo_q, tmo_d;
  logic [CW-1:0]        runc_q, runc_d;
  logic                 timeout_q, timeout_d;

  logic                 clr;
  logic                 last_core;
  logic [AW-1:0]        cur_base;
  logic [AW:0]          cur_len;
  logic [N_CORES-1:0]   flag_nx;

  assign cur_base = WIN_BASE[int'(cur_q)*AW +: AW];
  assign cur_len  = WIN_LEN[int'(cur_q)*(AW+1) +: AW+1];

  // per-core sticky done flags
  for (genvar g = 0; g < N_CORES; g++) begin : g_flag
    program_loader_flag u_flag (
      .clk       (clk),
      .init      (init),
      .clr       (clr),
      .kick      (core_start[g]),
      .run       (state_q == ST_RUN),
      .core_done (core_done[g]),
      .flag_nx   (flag_nx[g])
    );
  end

  // next-state, read issue and counters
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    runc_d    = runc_q;
    timeout_d = timeout_q;
    wr_en_d   = '0;
    wr_addr_d = '0;
    src_addr  = '0;
    clr       = 1'b0;
    last_core = (cur_q == CCW'(N_CORES - 1));
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          mode_d    = mode;
          cur_d     = '0;
          cnt_d     = '0;
          tmo_d     = '0;
          runc_d    = '0;
          timeout_d = 1'b0;
          clr       = 1'b1;
        end
      end
      ST_LOAD: begin
        // cnt 0..len-1 issue reads; cnt == len drains the last write
        if (cnt_q < cur_len) begin
          src_addr         = cur_base + cnt_q[AW-1:0];
          wr_en_d[cur_q]   = 1'b1;
          wr_addr_d        = src_addr;
          cnt_d            = cnt_q + (AW+1)'(1);
        end else begin
          cnt_d = '0;
          if (mode_q || last_core) state_d = ST_KICK;
          else                     cur_d   = cur_q + CCW'(1);
        end
      end
      ST_KICK: state_d = ST_RUN;
      ST_RUN: begin
        tmo_d = tmo_q + 32'd1;
        if (runc_q != '1) runc_d = runc_q + CW'(1);
        // completion wins over a timeout reached on the same edge
        if (mode_q ? flag_nx[cur_q] : &flag_nx) begin
          if (mode_q && !last_core) begin
            state_d = ST_LOAD;
            cur_d   = cur_q + CCW'(1);
          end else begin
            state_d = ST_DONE;
          end
        end else if (tmo_d >= 32'(TIMEOUT)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and pipeline registers
  always_ff @(posedge clk) begin
    if (init) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      cur_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      tmo_q     <= '0;
      runc_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      tmo_q     <= tmo_d;
      runc_q    <= runc_d;
      timeout_q <= timeout_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = (|wr_en_q) ? src_data : '0;
  assign core_start = (state_q != ST_KICK) ? '0 :
                      mode_q ? (N_CORES'(1) << cur_q) : '1;
  assign cur_core   = cur_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_KICK) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign run_cycles = runc_q;
endmodule

// File: tb/tb_program_loader_seq.sv
// Bench for program_loader_seq: two instances (default windows, and edge
// windows with a short timeout), a reactive core model, and a reference that
// derives writes, kicks, run cycles and done timing from the window table.
module tb_program_loader_seq;
  localparam int N = 3;

  logic clk = 1'b0;
  logic init = 1'b1;
  logic mode_r = 1'b0;
  logic start_r [2];
  logic [N-1:0] cd_r [2];
  logic [7:0] sa_w [2];
  logic [7:0] sd_r [2];
  logic [N-1:0] wr_en_w [2];
  logic [7:0] wr_addr_w [2];
  logic [7:0] wr_data_w [2];
  logic [N-1:0] cs_w [2];
  logic [1:0] cur_w [2];
  logic busy_w [2];
  logic done_w [2];
  logic to_w [2];
  logic [15:0] rc_w [2];

  logic [7:0] mem [256];
  int base_t [2][N] = '{'{1, 32, 128}, '{1, 32, 254}};
  int len_t  [2][N] = '{'{3, 64, 20}, '{3, 0, 4}};
  int to_t   [2]    = '{65535, 50};
  int dly [N];
  bit stuck [N];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) for (int i = 0; i < 2; i++) sd_r[i] <= mem[sa_w[i]];

  program_loader_seq u_dut0 (
    .clk(clk), .init(init), .start(start_r[0]), .mode(mode_r),
    .src_addr(sa_w[0]), .src_data(sd_r[0]), .wr_en(wr_en_w[0]),
    .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]), .core_start(cs_w[0]),
    .core_done(cd_r[0]), .cur_core(cur_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .timeout(to_w[0]), .run_cycles(rc_w[0]));

  program_loader_seq #(
    .WIN_BASE({8'hFE, 8'd32, 8'd1}), .WIN_LEN({9'd4, 9'd0, 9'd3}), .TIMEOUT(50)
  ) u_dut1 (
    .clk(clk), .init(init), .start(start_r[1]), .mode(mode_r),
    .src_addr(sa_w[1]), .src_data(sd_r[1]), .wr_en(wr_en_w[1]),
    .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]), .core_start(cs_w[1]),
    .core_done(cd_r[1]), .cur_core(cur_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .timeout(to_w[1]), .run_cycles(rc_w[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input int core, input int addr, input logic [7:0] data);
    pack = {8'd0, 8'(core), 8'(addr), data};
  endfunction

  function automatic int need_of(input int j);
    if (stuck[j]) need_of = 1;
    else if (dly[j] < 0) need_of = 1 << 30;
    else need_of = dly[j];
  endfunction

  task automatic chk_idle(input int ii, input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en_w[ii]), 0);
    chk({tag, "_cstart"}, 32'(cs_w[ii]), 0);
    chk({tag, "_busy"}, 32'(busy_w[ii]), 0);
    chk({tag, "_done"}, 32'(done_w[ii]), 0);
    chk({tag, "_tmo"}, 32'(to_w[ii]), 0);
    chk({tag, "_rc"}, 32'(rc_w[ii]), 0);
    chk({tag, "_cur"}, 32'(cur_w[ii]), 0);
    chk({tag, "_saddr"}, 32'(sa_w[ii]), 0);
    chk({tag, "_waddr"}, 32'(wr_addr_w[ii]), 0);
    chk({tag, "_wdata"}, 32'(wr_data_w[ii]), 0);
  endtask

  // One full sequence on instance ii; gl > 0 pulses start again gl cycles in.
  task automatic run_seq(input int ii, input bit md, input int gl, input string tag);
    logic [31:0] exp_w[$], act_w[$], exp_p[$], act_p[$];
    int acc, tot, ldc, exp_done, s, first_w, done_c, onehot_bad, cur_bad, idx;
    int pt [N];
    bit tmo;
    acc = 0; tmo = 0; ldc = 0;
    if (!md) begin
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < len_t[ii][k]; i++)
          exp_w.push_back(pack(k, (base_t[ii][k] + i) % 256, mem[(base_t[ii][k] + i) % 256]));
        ldc += len_t[ii][k] + 1;
      end
      exp_p.push_back(32'((1 << N) - 1));
      tot = 0;
      for (int j = 0; j < N; j++) if (need_of(j) > tot) tot = need_of(j);
      if (tot > to_t[ii]) begin acc = to_t[ii]; tmo = 1; end
      else acc = tot;
      exp_done = 2 + ldc + acc;
    end else begin
      exp_done = 1;
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < len_t[ii][k]; i++)
          exp_w.push_back(pack(k, (base_t[ii][k] + i) % 256, mem[(base_t[ii][k] + i) % 256]));
        exp_done += len_t[ii][k] + 2;
        exp_p.push_back(32'(1 << k));
        if (acc + need_of(k) > to_t[ii]) begin
          exp_done += to_t[ii] - acc; acc = to_t[ii]; tmo = 1;
          break;
        end
        acc += need_of(k);
        exp_done += need_of(k);
      end
    end
    if (acc > 65535) acc = 65535;

    for (int j = 0; j < N; j++) pt[j] = -1;
    first_w = -1; done_c = -1; onehot_bad = 0; cur_bad = 0;
    @(negedge clk);
    for (int j = 0; j < N; j++) cd_r[ii][j] = stuck[j];
    start_r[ii] = 1'b1; mode_r = md; s = cyc;
    for (int c = 0; c < 3000 && done_c < 0; c++) begin
      @(negedge clk);
      start_r[ii] = (gl > 0 && cyc == s + gl);
      if (wr_en_w[ii] != 0) begin
        idx = 0;
        for (int j = 0; j < N; j++) if (wr_en_w[ii][j]) idx = j;
        if ($countones(wr_en_w[ii]) != 1) onehot_bad++;
        else if (int'(cur_w[ii]) != idx) cur_bad++;
        act_w.push_back(pack(idx, int'(wr_addr_w[ii]), wr_data_w[ii]));
        if (first_w < 0) first_w = cyc - s;
      end
      if (cs_w[ii] != 0) begin
        act_p.push_back(32'(cs_w[ii]));
        for (int j = 0; j < N; j++) if (cs_w[ii][j]) pt[j] = cyc;
      end
      for (int j = 0; j < N; j++)
        cd_r[ii][j] = stuck[j] || (pt[j] >= 0 && dly[j] > 0 && cyc >= pt[j] + dly[j]);
      if (done_w[ii]) done_c = cyc - s;
    end
    start_r[ii] = 1'b0;
    chk({tag, "_done_cyc"}, 32'(done_c), 32'(exp_done));
    chk({tag, "_nwr"}, 32'(act_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++)
      chk({tag, "_wr"}, act_w[i], exp_w[i]);
    if (exp_w.size() > 0) chk({tag, "_first_wr"}, 32'(first_w), 2);
    chk({tag, "_npulse"}, 32'(act_p.size()), 32'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && i < act_p.size(); i++)
      chk({tag, "_pulse"}, act_p[i], exp_p[i]);
    chk({tag, "_onehot"}, 32'(onehot_bad), 0);
    chk({tag, "_cur"}, 32'(cur_bad), 0);
    chk({tag, "_rc"}, 32'(rc_w[ii]), 32'(acc));
    chk({tag, "_tmo"}, 32'(to_w[ii]), 32'(tmo));
    chk({tag, "_busy"}, 32'(busy_w[ii]), 0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 2; i++) begin start_r[i] = 1'b0; cd_r[i] = '0; end
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    for (int j = 0; j < N; j++) begin dly[j] = 10; stuck[j] = 0; end
    repeat (3) @(negedge clk);
    init = 1'b0;
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");

    run_seq(0, 0, 0, "par");
    run_seq(0, 1, 0, "rot");
    run_seq(1, 0, 0, "edge_par");
    run_seq(1, 1, 0, "edge_rot");
    dly[1] = -1;
    run_seq(1, 0, 0, "tmo_par");
    run_seq(1, 1, 0, "tmo_rot");
    dly[1] = 10;

    // init in the middle of core 1's load
    @(negedge clk);
    start_r[0] = 1'b1; mode_r = 1'b0; s = cyc;
    @(negedge clk);
    start_r[0] = 1'b0;
    while (cyc < s + 10) @(negedge clk);
    chk("mid_cur", 32'(cur_w[0]), 1);
    chk("mid_busy", 32'(busy_w[0]), 1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk_idle(0, "init");
    run_seq(0, 0, 0, "reload");

    // core 2 done stuck high, plus a stray start while running
    stuck[2] = 1;
    @(negedge clk);
    cd_r[0] = 3'b100;
    repeat (4) @(negedge clk);
    run_seq(0, 1, 8, "stuck");
    stuck[2] = 0;

    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      for (int j = 0; j < N; j++) dly[j] = int'($urandom_range(1, 15));
      run_seq(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/program_loader_seq.md
Name: program_loader_seq

Overview:
- Parametrised test-harness sequencer for N program cores.
- Copies each core's data window from a shared source memory into that core's data RAM through a write port, one word per cycle.
- Releases the cores with a start pulse and collects sticky per-core done flags.
- Two modes: parallel (load all cores, run all) and rotate (load, run and finish each core in turn). Adds a run timeout and a cycle counter.

Parameters:
- N_CORES, 3, number of cores/channels.
- AW, 8, address width of the source and destination memories.
- DW, 8, data width.
- WIN_BASE, {8'd128,8'd32,8'd1}, packed N_CORES×AW; start address of each core's window (core 0 in the LSBs).
- WIN_LEN, {9'd20,9'd64,9'd3}, packed N_CORES×(AW+1); window length in words, 0..2^AW.
- TIMEOUT, 65535, maximum RUN cycles before abort.
- CW, 16, width of the cycle counter.

Ports:
- clk  in  1  clock.
- init  in  1  synchronous active-high reset.
- start  in  1  begin a load/run sequence; ignored unless the state is IDLE or DONE.
- mode  in  1  0 = parallel, 1 = rotate; sampled on an accepted start.
- src_addr  out  AW  source memory read address.
- src_data  in  DW  source read data, 1-cycle synchronous latency.
- wr_en  out  N_CORES  one-hot destination write enable.
- wr_addr  out  AW  destination address (same as the source address).
- wr_data  out  DW  destination data.
- core_start  out  N_CORES  1-cycle start pulse per core.
- core_done  in  N_CORES  level done from each core.
- cur_core  out  $clog2(N_CORES)  index of the core being loaded or run.
- busy  out  1  high in LOAD and RUN.
- done  out  1  sequence finished; held until the next accepted start or init.
- timeout  out  1  sequence aborted by timeout; valid while done is high.
- run_cycles  out  CW  cycles spent in RUN, saturating.

Behaviour:
- Reset (init high at a clock edge, overrides everything including mid-operation):
  - State goes to IDLE.
  - All outputs are 0 from the next cycle: wr_en, core_start, busy, done, timeout, run_cycles, cur_core, src_addr, wr_addr, wr_data.
  - Done flags are cleared.
- States: IDLE, LOAD, RUN, DONE.
- Accepted start (IDLE or DONE):
  - Latches mode; done, timeout, run_cycles and flags cleared; cur_core=0.
  - Next state LOAD.
- LOAD for core k, with i = 0..WIN_LEN[k]-1:
  - Cycle t: src_addr = WIN_BASE[k]+i, wrapping mod 2^AW.
  - Cycle t+1: wr_en[k]=1, wr_addr = that address, wr_data = src_data.
  - Reads are pipelined: a window of L words takes exactly L+1 cycles.
  - WIN_LEN=0: no writes; 1-cycle pass-through.
  - wr_en is never asserted for more than one core in the same cycle.
- Parallel mode:
  - LOAD runs cores 0..N-1 back to back.
  - Then one cycle with core_start = all ones, entering RUN.
  - RUN ends when every flag is set.
- Rotate mode:
  - LOAD core k, then core_start[k] pulse, then RUN until flag[k] is set.
  - Then k+1 and LOAD again; after core N-1, go to DONE.
- Flags:
  - flag[j] is cleared in the cycle core_start[j] pulses; it is set when core_done[j]=1 on any later edge while in RUN.
  - A core_done already high before the start pulse is therefore counted only if still high one cycle after the pulse.
  - core_done of a core not yet started is ignored.
- run_cycles:
  - Increments each RUN cycle and saturates at 2^CW-1.
  - In rotate mode it accumulates across all cores.
- Timeout:
  - If RUN cycles in the current sequence reach TIMEOUT: go to DONE with timeout=1.
  - Remaining cores are not loaded or started.
- DONE: done=1, busy=0.
  - Start and a new completion in the same cycle: the start is accepted on the following cycle only.
- start held high is accepted only in IDLE or DONE; a start during LOAD or RUN has no effect.

Test Plan:
- Parallel, default windows, src[a]=a^8'h5A, all cores raise done 10 cycles after their start -> 3+64+20 writes with correct addr/data; wr_en[0] first at cycle 2 after start; single all-ones core_start; done=1; run_cycles=10; timeout=0.
- Rotate, same stimulus -> write bursts per core interleaved with single core_start[k] pulses in order 0,1,2; cur_core 0→1→2; run_cycles=30.
- WIN_LEN core1=0, WIN_BASE core2=8'hFE with length 4 -> no wr_en[1]; core2 writes addresses FE,FF,00,01.
- TIMEOUT=50, core 1 never done, parallel -> done=1, timeout=1, run_cycles=50; rotate -> core 2 never loaded or started.
- init pulsed mid-LOAD of core 1 -> next cycle all outputs 0, state IDLE; a later start reloads from core 0.
- core_done[2] stuck high from reset, rotate mode -> ignored until core_start[2]; flag[2] set one cycle after that pulse; start asserted during RUN has no effect.
